framebuffer_write: RTL and testbench

FRAMEBUFFER_WRITE -- requirements
Module: framebuffer_write

---
 rtl/framebuffer_write_pkg.sv | 15 +
 rtl/fb_write_fifo.sv | 67 ++++++
 rtl/framebuffer_write.sv | 158 +++++++++++++++
 tb/tb_framebuffer_write.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_write_pkg.sv
// Shared framebuffer constants and master FSM encoding.
// Used by both the framebuffer writer and reader.
package framebuffer_write_pkg;

    localparam logic [28:0] FB_BASE_ADDRESS = 29'h0700_0000;
    localparam int          FB_FRAME_WORDS  = 153600;
    localparam logic [7:0]  FB_BURSTCOUNT   = 8'h01;
    localparam logic [7:0]  FB_BYTEENABLE   = 8'hFF;

    typedef enum logic {
        FB_IDLE = 1'b0,
        FB_WAIT = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_write_fifo.sv
// Packed-word FIFO between the pixel packer and the Avalon master.
// Push and pop may coincide at any fill level; flush empties it.
module fb_write_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];

    // Pointer and occupancy next-state.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push)
                              - (AW+1)'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/framebuffer_write.sv
// Packs 32-bit pixels in pairs and writes them to the
// framebuffer as single-word Avalon-MM writes.
module framebuffer_write
    import framebuffer_write_pkg::*;
#(
    parameter logic [28:0] BASE_ADDRESS = FB_BASE_ADDRESS,
    parameter int          FRAME_WORDS  = FB_FRAME_WORDS,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        frame_start,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    output logic [7:0]  byteenable,
    output logic [63:0] writedata,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic        frame_done,
    output logic        busy
);

    localparam int OW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [OW-1:0] LAST = OW'(FRAME_WORDS - 1);

    fb_state_e     state_q, state_d;
    logic [OW-1:0] offset_q, offset_d;
    logic          restart_q, restart_d;
    logic          half_q, half_d;
    logic [31:0]   low_q, low_d;
    logic          write_q, write_d;
    logic [28:0]   address_q, address_d;
    logic [63:0]   data_q, data_d;
    logic          done_q, done_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [63:0]   head;
    logic          fifo_full;
    logic          fifo_empty;

    assign pixel_ready = !fifo_full && !reset;
    assign accept      = pixel_valid && pixel_ready;

    fb_write_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (frame_start),
        .push      (push),
        .push_data ({pixel_data, low_q}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pixel packer: low half first, push on the second pixel.
    always_comb begin
        half_d = half_q;
        low_d  = low_q;
        push   = 1'b0;
        if (frame_start) begin
            half_d = accept;
            if (accept) low_d = pixel_data;
        end else if (accept) begin
            if (half_q) begin
                push   = 1'b1;
                half_d = 1'b0;
            end else begin
                low_d  = pixel_data;
                half_d = 1'b1;
            end
        end
    end

    // Avalon master: launch from IDLE, hold in WAIT until accepted.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        restart_d = restart_q;
        write_d   = write_q;
        address_d = address_q;
        data_d    = data_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            FB_IDLE: begin
                if (frame_start) begin
                    offset_d = '0;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    write_d   = 1'b1;
                    address_d = BASE_ADDRESS + 29'(offset_q);
                    data_d    = head;
                    state_d   = FB_WAIT;
                end
            end
            FB_WAIT: begin
                if (frame_start) restart_d = 1'b1;
                if (!waitrequest) begin
                    write_d   = 1'b0;
                    address_d = '0;
                    data_d    = '0;
                    done_d    = (offset_q == LAST);
                    restart_d = 1'b0;
                    state_d   = FB_IDLE;
                    if (restart_q || frame_start || offset_q == LAST)
                        offset_d = '0;
                    else
                        offset_d = offset_q + OW'(1);
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // State registers; reset drops any write in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FB_IDLE;
            offset_q  <= '0;
            restart_q <= 1'b0;
            half_q    <= 1'b0;
            low_q     <= '0;
            write_q   <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            restart_q <= restart_d;
            half_q    <= half_d;
            low_q     <= low_d;
            write_q   <= write_d;
            address_q <= address_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign address    = address_q;
    assign writedata  = data_q;
    assign write      = write_q;
    assign burstcount = FB_BURSTCOUNT;
    assign byteenable = FB_BYTEENABLE;
    assign read       = 1'b0;
    assign frame_done = done_q;
    assign busy       = !fifo_empty || half_q || write_q;

endmodule

// File: tb/tb_framebuffer_write.sv
// Scoreboard bench for framebuffer_write: a pixel-stream model
// predicts every Avalon write; a monitor pops and compares.
module tb_framebuffer_write;

    localparam logic [28:0] BASE = 29'h0700_0000;
    localparam int          FW   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        frame_start = 1'b0;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic [7:0]  byteenable;
    logic [63:0] writedata;
    logic        write;
    logic        read;
    logic        waitrequest = 1'b0;
    logic        frame_done;
    logic        busy;

    bit wr_mode = 1'b0;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  total  = 0;
    int  done_pulses = 0;

    bit          m_half = 1'b0;
    logic [31:0] m_low  = '0;
    int          m_idx  = 0;

    framebuffer_write #(
        .BASE_ADDRESS (BASE),
        .FRAME_WORDS  (FW),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .frame_start  (frame_start),
        .address      (address),
        .burstcount   (burstcount),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .write        (write),
        .read         (read),
        .waitrequest  (waitrequest),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random slave stall when enabled.
    initial forever begin
        @(posedge clock);
        #1;
        if (wr_mode) waitrequest = ($urandom_range(0, 2) == 0);
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    // Model: frame boundary drops the half pair and restarts offsets.
    function automatic void m_frame(input int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        m_half = 1'b0;
        m_idx  = 0;
    endfunction

    function automatic void m_pixel(input logic [31:0] d);
        wr_t e;
        if (m_half) begin
            e.addr = BASE + 29'(m_idx);
            e.data = {d, m_low};
            exp_q.push_back(e);
            m_idx  = (m_idx + 1) % FW;
            m_half = 1'b0;
        end else begin
            m_low  = d;
            m_half = 1'b1;
        end
    endfunction

    task automatic send_px(input logic [31:0] d, input bit fs);
        int n = 0;
        pixel_data  = d;
        pixel_valid = 1'b1;
        frame_start = fs;
        forever begin
            @(negedge clock);
            if (pixel_ready) break;
            n++;
            if (n > 1000) begin
                total++;
                $display("FAIL send_px: no pixel_ready got 0 want 1");
                pixel_valid = 1'b0;
                frame_start = 1'b0;
                return;
            end
        end
        @(posedge clock);
        if (fs) m_frame(0);
        m_pixel(d);
        #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fstart(input int keep);
        frame_start = 1'b1;
        @(posedge clock);
        m_frame(keep);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || write) && n < 1000) begin
            @(posedge clock);
            n++;
        end
        total++;
        if (exp_q.size() == 0 && !write) passed++;
        else $display("FAIL drain: outstanding got %0d want 0",
                      exp_q.size());
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic wait_write();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!write && n < 200);
        check("wait_write", 64'(write), 64'(1));
    endtask

    // Monitor: compares accepted writes and Avalon protocol rules.
    initial begin
        bit          pw = 0;
        bit          pwait = 0;
        bit          post = 0;
        bit          exp_done = 0;
        logic [28:0] pa = '0;
        logic [63:0] pd = '0;
        wr_t         e;
        forever begin
            @(negedge clock);
            if (reset) begin
                pw = 0;
                post = 0;
                exp_done = 0;
            end else begin
                check("frame_done", 64'(frame_done), 64'(exp_done));
                if (frame_done) done_pulses++;
                exp_done = 0;
                if (post) begin
                    check("write_drop", 64'(write), 64'(0));
                    check("addr_clear", 64'(address), 64'(0));
                    check("data_clear", writedata, 64'(0));
                end
                if (pw && pwait) begin
                    check("stall_write", 64'(write), 64'(1));
                    check("stall_addr", 64'(address), 64'(pa));
                    check("stall_data", writedata, pd);
                end
                post = 0;
                if (write && !waitrequest) begin
                    post = 1;
                    total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_write: addr %h data %h",
                                 address, writedata);
                    end else begin
                        passed++;
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(address), 64'(e.addr));
                        check("wr_data", writedata, e.data);
                        exp_done = (e.addr == BASE + 29'(FW - 1));
                    end
                end
                pw    = write;
                pwait = waitrequest;
                pa    = address;
                pd    = writedata;
            end
        end
    end

    initial begin
        int acc;
        int idle_cnt;
        int d0;
        int n;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_write", 64'(write), 64'(0));
        check("rst_addr", 64'(address), 64'(0));
        check("rst_data", writedata, 64'(0));
        check("rst_ready", 64'(pixel_ready), 64'(0));
        check("rst_done", 64'(frame_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("burstcount", 64'(burstcount), 64'h01);
        check("byteenable", 64'(byteenable), 64'hFF);
        check("read", 64'(read), 64'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        m_frame(0);

        // Single pair, no stall.
        send_px(32'h11, 0);
        send_px(32'h22, 0);
        drain();
        check("busy_idle", 64'(busy), 64'(0));

        // First write stalled five cycles.
        fstart(0);
        waitrequest = 1'b1;
        send_px(32'h0000_0101, 0);
        send_px(32'h0000_0202, 0);
        send_px(32'h0000_0303, 0);
        send_px(32'h0000_0404, 0);
        wait_write();
        repeat (5) @(posedge clock);
        #1 waitrequest = 1'b0;
        drain();

        // Backpressure with the slave stalled.
        waitrequest = 1'b1;
        acc = 0;
        idle_cnt = 0;
        for (int c = 0; c < 100 && idle_cnt < 4; c++) begin
            pixel_valid = 1'b1;
            pixel_data  = $urandom;
            @(negedge clock);
            if (pixel_ready) begin
                @(posedge clock);
                m_pixel(pixel_data);
                acc++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                @(posedge clock);
            end
            #1;
        end
        pixel_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(18));
        @(negedge clock);
        check("bp_ready_low", 64'(pixel_ready), 64'(0));
        @(posedge clock);
        #1 waitrequest = 1'b0;
        drain();

        // Frame wrap with random stalls.
        fstart(0);
        d0 = done_pulses;
        wr_mode = 1'b1;
        for (int i = 0; i < 10; i++) send_px($urandom, 0);
        drain();
        wr_mode = 1'b0;
        waitrequest = 1'b0;
        check("done_pulses", 64'(done_pulses - d0), 64'(1));

        // Partial pair discarded by frame_start.
        send_px(32'h5A, 0);
        @(negedge clock);
        check("busy_half", 64'(busy), 64'(1));
        @(posedge clock);
        #1;
        fstart(0);
        send_px(32'hAA, 0);
        send_px(32'hBB, 0);
        drain();

        // frame_start coincident with an accepted pixel.
        send_px(32'h33, 0);
        send_px(32'h44, 1);
        send_px(32'h55, 0);
        drain();

        // frame_start flushes FIFO; in-flight write completes.
        waitrequest = 1'b1;
        send_px(32'hE1, 0);
        send_px(32'hE2, 0);
        send_px(32'hE3, 0);
        send_px(32'hE4, 0);
        send_px(32'hE5, 0);
        send_px(32'hE6, 0);
        wait_write();
        @(posedge clock);
        #1;
        fstart(1);
        send_px(32'hF1, 0);
        send_px(32'hF2, 0);
        @(posedge clock);
        #1 waitrequest = 1'b0;
        drain();

        // Randomized traffic.
        wr_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(8, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clock);
                    #1;
                end
                send_px($urandom, (i == 0) && (r % 2 == 1));
            end
            drain();
            if (r % 3 == 2) fstart(0);
        end
        wr_mode = 1'b0;
        waitrequest = 1'b0;
        drain();

        // Reset during a stalled write.
        waitrequest = 1'b1;
        send_px(32'hD1, 0);
        send_px(32'hD2, 0);
        wait_write();
        #2 reset = 1'b1;
        #1;
        check("arst_write", 64'(write), 64'(0));
        check("arst_addr", 64'(address), 64'(0));
        check("arst_ready", 64'(pixel_ready), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        m_frame(0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        send_px(32'hC1, 0);
        send_px(32'hC2, 0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
